version_fetch: RTL and testbench

APB master that reads the four 16-bit FPGA identification words (magic, version bytes 1–3) from the version ROM slave and holds them in registers for the rest of the fabric. It sits directly upstream of the version ROM on a dedicated APB segment. It fetches once automatically after reset and again on request, and it reports slave errors and timeouts.

---
 rtl/version_fetch.sv | 145 ++++++++++++++
 tb/tb_version_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/version_fetch.sv
// APB master that reads the four 16-bit FPGA identification words from the
// version ROM once after reset and on request, and holds them for the fabric.
module version_fetch #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] EXPECTED_MAGIC = 16'hA2F5
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        refetch,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [3:0]  PADDR,
    output logic [15:0] PWDATA,
    input  logic [15:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic [15:0] magic,
    output logic [15:0] ver1,
    output logic [15:0] ver2,
    output logic [15:0] ver3,
    output logic        ver_valid,
    output logic        magic_ok,
    output logic        busy,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  wait_q, wait_d;
    logic        start_pending_q, start_pending_d;
    logic [15:0] magic_q, magic_d;
    logic [15:0] ver1_q, ver1_d;
    logic [15:0] ver2_q, ver2_d;
    logic [15:0] ver3_q, ver3_d;
    logic        ver_valid_q, ver_valid_d;
    logic [1:0]  err_q, err_d;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q         <= IDLE;
            idx_q           <= 2'd0;
            wait_q          <= 8'd0;
            start_pending_q <= 1'b1;
            magic_q         <= 16'd0;
            ver1_q          <= 16'd0;
            ver2_q          <= 16'd0;
            ver3_q          <= 16'd0;
            ver_valid_q     <= 1'b0;
            err_q           <= 2'b00;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            wait_q          <= wait_d;
            start_pending_q <= start_pending_d;
            magic_q         <= magic_d;
            ver1_q          <= ver1_d;
            ver2_q          <= ver2_d;
            ver3_q          <= ver3_d;
            ver_valid_q     <= ver_valid_d;
            err_q           <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        wait_d          = wait_q;
        start_pending_d = start_pending_q;
        magic_d         = magic_q;
        ver1_d          = ver1_q;
        ver2_d          = ver2_q;
        ver3_d          = ver3_q;
        ver_valid_d     = ver_valid_q;
        err_d           = err_q;
        case (state_q)
            IDLE: begin
                // refetch is only looked at here, so requests while busy are dropped
                if (start_pending_q || refetch) begin
                    state_d         = SETUP;
                    start_pending_d = 1'b0;
                    idx_d           = 2'd0;
                    ver_valid_d     = 1'b0;
                    err_d           = 2'b00;
                end
            end
            SETUP: begin
                wait_d  = 8'd0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        err_d   = 2'b01;
                        state_d = IDLE;
                    end else begin
                        case (idx_q)
                            2'd0:    magic_d = PRDATA;
                            2'd1:    ver1_d  = PRDATA;
                            2'd2:    ver2_d  = PRDATA;
                            default: ver3_d  = PRDATA;
                        endcase
                        if (idx_q == 2'd3) begin
                            ver_valid_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = SETUP;
                        end
                    end
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 2'b10;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // idx_q is stable across SETUP and ACCESS, so the address holds by construction
    assign PSEL     = (state_q != IDLE);
    assign PENABLE  = (state_q == ACCESS);
    assign PADDR    = (state_q == IDLE) ? 4'd0 : {idx_q, 2'b00};
    assign PWRITE   = 1'b0;
    assign PWDATA   = 16'd0;
    assign busy     = (state_q != IDLE);
    assign magic    = magic_q;
    assign ver1     = ver1_q;
    assign ver2     = ver2_q;
    assign ver3     = ver3_q;
    assign ver_valid = ver_valid_q;
    assign magic_ok = ver_valid_q && (magic_q == EXPECTED_MAGIC);
    assign err_code = err_q;

endmodule

// File: tb/tb_version_fetch.sv
// Directed bench for version_fetch: a ROM slave driven from a table, one DUT
// with the default timeout and a second one with TIMEOUT_CYCLES=4.
module tb_version_fetch;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        refetch;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [15:0] magic, ver1, ver2, ver3;
  logic        ver_valid, magic_ok, busy;
  logic [1:0]  err_code;

  logic        b_rst_n, b_refetch;
  logic        b_psel, b_penable, b_pwrite;
  logic [3:0]  b_paddr;
  logic [15:0] b_pwdata;
  logic [15:0] b_prdata;
  logic        b_pready, b_pslverr;
  logic [15:0] b_magic, b_ver1, b_ver2, b_ver3;
  logic        b_ver_valid, b_magic_ok, b_busy;
  logic [1:0]  b_err_code;

  logic [15:0] rom [4];
  int tests = 0;
  int fails = 0;
  int reads = 0;
  int read_base;

  always #5 PCLK = ~PCLK;

  assign PRDATA = rom[PADDR[3:2]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY) reads <= reads + 1;
  end

  version_fetch dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .refetch(refetch),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .magic(magic), .ver1(ver1), .ver2(ver2), .ver3(ver3),
    .ver_valid(ver_valid), .magic_ok(magic_ok), .busy(busy), .err_code(err_code)
  );

  version_fetch #(.TIMEOUT_CYCLES(4)) dut_b (
    .PCLK(PCLK), .PRESETn(b_rst_n), .refetch(b_refetch),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr),
    .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr),
    .magic(b_magic), .ver1(b_ver1), .ver2(b_ver2), .ver3(b_ver3),
    .ver_valid(b_ver_valid), .magic_ok(b_magic_ok), .busy(b_busy), .err_code(b_err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_refetch();
    refetch = 1'b1;
    step();
    refetch = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; refetch = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0;
    b_rst_n = 1'b0; b_refetch = 1'b0; b_prdata = 16'h0; b_pready = 1'b0; b_pslverr = 1'b0;
    rom[0] = 16'hA2F5; rom[1] = 16'h0001; rom[2] = 16'h0002; rom[3] = 16'h0000;

    // reset values
    repeat (2) @(negedge PCLK);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_outs", {magic, ver1, ver2, ver3} == 64'd0, 1);
    check("rst_flags", {ver_valid, magic_ok, busy, err_code}, 0);

    // automatic fetch after reset, zero wait states
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("auto_setup%0d", k), {PSEL, PENABLE, PADDR}, {2'b10, 4'(4 * k)});
      step();
      check($sformatf("auto_access%0d", k), {PSEL, PENABLE, PADDR}, {2'b11, 4'(4 * k)});
    end
    check("auto_valid_e8", ver_valid, 0);
    check("auto_busy_e8", busy, 1);
    step();
    check("auto_busy_e9", busy, 0);
    check("auto_psel_e9", PSEL, 0);
    check("auto_valid", ver_valid, 1);
    check("auto_magic_ok", magic_ok, 1);
    check("auto_err", err_code, 2'b00);
    check("auto_words", {magic, ver1, ver2, ver3}, 64'hA2F5_0001_0002_0000);
    step();
    check("auto_stays_idle", busy, 0);

    // wrong magic
    rom[0] = 16'h1234;
    pulse_refetch();
    check("bad_busy_e1", busy, 1);
    check("bad_valid_cleared", ver_valid, 0);
    steps(8);
    check("bad_valid", ver_valid, 1);
    check("bad_magic_ok", magic_ok, 0);
    check("bad_magic", magic, 16'h1234);

    // three wait states on word 2: ACCESS2 held through edges 6..9, done at edge 12
    rom[0] = 16'hA2F5; rom[1] = 16'h0011; rom[2] = 16'h0022; rom[3] = 16'h0033;
    pulse_refetch();
    steps(5);
    PREADY = 1'b0;
    check("ws_hold_e6", {PENABLE, PADDR}, {1'b1, 4'd8});
    for (int e = 7; e <= 9; e++) begin
      step();
      check($sformatf("ws_hold_e%0d", e), {PENABLE, PADDR}, {1'b1, 4'd8});
    end
    PREADY = 1'b1;
    step();
    check("ws_setup3_e10", {PSEL, PENABLE, PADDR}, {2'b10, 4'd12});
    step();
    check("ws_busy_e11", busy, 1);
    step();
    check("ws_done_e12", {busy, ver_valid, magic_ok}, 3'b011);
    check("ws_words", {magic, ver1, ver2, ver3}, 64'hA2F5_0011_0022_0033);

    // slave error on word 1 (ACCESS1 entered at edge 4, error taken at edge 5)
    rom[1] = 16'h0101; rom[2] = 16'h0202; rom[3] = 16'h0303;
    pulse_refetch();
    steps(3);
    PSLVERR = 1'b1;
    check("err_access1", {PENABLE, PADDR}, {1'b1, 4'd4});
    step();
    PSLVERR = 1'b0;
    check("err_code", err_code, 2'b01);
    check("err_idle", {PSEL, busy}, 2'b00);
    check("err_valid", {ver_valid, magic_ok}, 2'b00);
    check("err_word1_kept", ver1, 16'h0011);
    check("err_word0_new", magic, 16'hA2F5);
    pulse_refetch();
    check("err_cleared", err_code, 2'b00);
    steps(8);
    check("err_recover_valid", ver_valid, 1);
    check("err_recover_err", err_code, 2'b00);
    check("err_recover_words", {ver1, ver2, ver3}, 48'h0101_0202_0303);

    // refetch during busy is dropped
    read_base = reads;
    pulse_refetch();
    steps(2);
    pulse_refetch();
    steps(5);
    check("drop_done", {busy, ver_valid}, 2'b01);
    steps(2);
    check("drop_not_queued", busy, 0);
    check("drop_reads", reads - read_base, 4);

    // asynchronous reset in ACCESS1, then automatic restart from address 0
    pulse_refetch();
    steps(3);
    check("mid_access1", {PENABLE, PADDR}, {1'b1, 4'd4});
    PRESETn = 1'b0;
    #1;
    check("mid_rst_bus", {PSEL, PENABLE, PADDR}, 0);
    check("mid_rst_words", {magic, ver1, ver2, ver3} == 64'd0, 1);
    check("mid_rst_flags", {ver_valid, magic_ok, busy, err_code}, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();
    check("mid_restart", {PSEL, PENABLE, PADDR, busy}, {2'b10, 4'd0, 1'b1});
    steps(8);
    check("mid_restart_done", {busy, ver_valid, magic_ok}, 3'b011);
    check("mid_restart_words", {magic, ver1, ver2, ver3}, 64'hA2F5_0101_0202_0303);

    // TIMEOUT_CYCLES=4 with PREADY stuck low on word 0
    @(negedge PCLK);
    b_rst_n = 1'b1;
    steps(5);
    check("to_wait_e5", {b_penable, b_busy, b_err_code}, 4'b1100);
    step();
    check("to_err_e6", b_err_code, 2'b10);
    check("to_idle_e6", {b_psel, b_busy, b_ver_valid}, 3'b000);
    step();
    check("to_stays_idle", b_psel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
